// File: rtl/clock_calendar_counter_if.sv
// Control and field bus of the clock/calendar counter.
// The master drives the edit controls; the slave presents the six time/date fields.
interface clock_calendar_counter_if;
  logic        tick_1hz;
  logic [2:0]  select_item;
  logic        inc_pulse;
  logic        dec_pulse;
  logic [5:0]  second;
  logic [5:0]  minute;
  logic [5:0]  hour;
  logic [5:0]  day;
  logic [3:0]  month;
  logic [13:0] year;

  modport master (
    output tick_1hz, select_item, inc_pulse, dec_pulse,
    input  second, minute, hour, day, month, year
  );

  modport slave (
    input  tick_1hz, select_item, inc_pulse, dec_pulse,
    output second, minute, hour, day, month, year
  );
endinterface

// File: rtl/clock_calendar_counter.sv
// Time-of-day and Gregorian calendar counter, years 0..9999.
// Advances on tick_1hz in run mode; single-field inc/dec editing otherwise.
module clock_calendar_counter (
  input logic                     clk,
  input logic                     rst_n,
  clock_calendar_counter_if.slave bus
);

  logic [5:0]  second_q, second_d;
  logic [5:0]  minute_q, minute_d;
  logic [5:0]  hour_q,   hour_d;
  logic [5:0]  day_q,    day_d;
  logic [3:0]  month_q,  month_d;
  logic [13:0] year_q,   year_d;

  logic [5:0] dim_cur;
  logic [5:0] dim_next;
  logic       edit_mode;
  logic       inc_only;
  logic       dec_only;

  function automatic logic is_leap(input logic [13:0] y);
    return (((y % 14'd4) == '0) && ((y % 14'd100) != '0)) || ((y % 14'd400) == '0);
  endfunction

  function automatic logic [5:0] days_in_month(input logic [3:0] m, input logic [13:0] y);
    logic [5:0] d;
    case (m)
      4'd4, 4'd6, 4'd9, 4'd11: d = 6'd30;
      4'd2:                    d = is_leap(y) ? 6'd29 : 6'd28;
      default:                 d = 6'd31;
    endcase
    return d;
  endfunction

  assign edit_mode = (bus.select_item != 3'd0) && (bus.select_item != 3'd7);
  assign inc_only  = bus.inc_pulse & ~bus.dec_pulse;
  assign dec_only  = bus.dec_pulse & ~bus.inc_pulse;
  assign dim_cur   = days_in_month(month_q, year_q);

  always_comb begin
    second_d = second_q;
    minute_d = minute_q;
    hour_d   = hour_q;
    day_d    = day_q;
    month_d  = month_q;
    year_d   = year_q;
    dim_next = '0;

    if (!edit_mode) begin
      if (bus.tick_1hz) begin
        // Full carry chain resolves in one edge.
        if (second_q == 6'd59) begin
          second_d = '0;
          if (minute_q == 6'd59) begin
            minute_d = '0;
            if (hour_q == 6'd23) begin
              hour_d = '0;
              if (day_q >= dim_cur) begin
                day_d = 6'd1;
                if (month_q == 4'd12) begin
                  month_d = 4'd1;
                  year_d  = (year_q == 14'd9999) ? '0 : year_q + 14'd1;
                end else begin
                  month_d = month_q + 4'd1;
                end
              end else begin
                day_d = day_q + 6'd1;
              end
            end else begin
              hour_d = hour_q + 6'd1;
            end
          end else begin
            minute_d = minute_q + 6'd1;
          end
        end else begin
          second_d = second_q + 6'd1;
        end
      end
    end else if (inc_only || dec_only) begin
      case (bus.select_item)
        3'd1: begin
          if (inc_only) second_d = (second_q == 6'd59) ? '0 : second_q + 6'd1;
          else          second_d = (second_q == '0) ? 6'd59 : second_q - 6'd1;
        end
        3'd2: begin
          if (inc_only) minute_d = (minute_q == 6'd59) ? '0 : minute_q + 6'd1;
          else          minute_d = (minute_q == '0) ? 6'd59 : minute_q - 6'd1;
        end
        3'd3: begin
          if (inc_only) hour_d = (hour_q == 6'd23) ? '0 : hour_q + 6'd1;
          else          hour_d = (hour_q == '0) ? 6'd23 : hour_q - 6'd1;
        end
        3'd4: begin
          if (inc_only) day_d = (day_q >= dim_cur) ? 6'd1 : day_q + 6'd1;
          else          day_d = (day_q <= 6'd1) ? dim_cur : day_q - 6'd1;
        end
        3'd5: begin
          if (inc_only) month_d = (month_q == 4'd12) ? 4'd1 : month_q + 4'd1;
          else          month_d = (month_q <= 4'd1) ? 4'd12 : month_q - 4'd1;
        end
        3'd6: begin
          if (inc_only) year_d = (year_q == 14'd9999) ? '0 : year_q + 14'd1;
          else          year_d = (year_q == '0) ? 14'd9999 : year_q - 14'd1;
        end
        default: ;
      endcase
    end

    // Clamp against the post-edit month/year so a shorter month never holds an invalid day.
    dim_next = days_in_month(month_d, year_d);
    if (day_d > dim_next) day_d = dim_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      second_q <= '0;
      minute_q <= '0;
      hour_q   <= '0;
      day_q    <= 6'd1;
      month_q  <= 4'd1;
      year_q   <= 14'd2000;
    end else begin
      second_q <= second_d;
      minute_q <= minute_d;
      hour_q   <= hour_d;
      day_q    <= day_d;
      month_q  <= month_d;
      year_q   <= year_d;
    end
  end

  assign bus.second = second_q;
  assign bus.minute = minute_q;
  assign bus.hour   = hour_q;
  assign bus.day    = day_q;
  assign bus.month  = month_q;
  assign bus.year   = year_q;

endmodule

// File: tb/tb_clock_calendar_counter.sv
// Scoreboard bench for clock_calendar_counter: directed calendar corner cases plus
// random run/edit traffic checked against an arithmetic time/date model.
module tb_clock_calendar_counter;

  typedef struct {
    int s;
    int mi;
    int h;
    int d;
    int mo;
    int y;
  } t_time;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int checks = 0;
  int errors = 0;

  t_time exp_q[$];
  t_time m;

  clock_calendar_counter_if bus ();

  clock_calendar_counter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit leap(input int y);
    return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
  endfunction

  function automatic int dim(input int mo, input int y);
    int t[12];
    t = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (mo == 2 && leap(y)) return 29;
    return t[mo - 1];
  endfunction

  function automatic int wrap(input int v, input int lo, input int hi);
    int n;
    n = hi - lo + 1;
    return lo + (((v - lo) % n) + n) % n;
  endfunction

  function automatic int model_get(input int sel);
    case (sel)
      1: return m.s;
      2: return m.mi;
      3: return m.h;
      4: return m.d;
      5: return m.mo;
      default: return m.y;
    endcase
  endfunction

  task automatic model_reset();
    m = '{s: 0, mi: 0, h: 0, d: 1, mo: 1, y: 2000};
  endtask

  task automatic model_update(input bit tick, input int sel, input bit inc, input bit dec);
    int sod;
    int dl;
    if (sel == 0 || sel == 7) begin
      if (tick) begin
        sod = m.h * 3600 + m.mi * 60 + m.s + 1;
        if (sod == 86400) begin
          sod = 0;
          if (m.d == dim(m.mo, m.y)) begin
            m.d = 1;
            if (m.mo == 12) begin
              m.mo = 1;
              m.y  = (m.y + 1) % 10000;
            end else m.mo++;
          end else m.d++;
        end
        m.s  = sod % 60;
        m.mi = (sod / 60) % 60;
        m.h  = sod / 3600;
      end
    end else if (inc != dec) begin
      dl = inc ? 1 : -1;
      case (sel)
        1: m.s  = wrap(m.s + dl, 0, 59);
        2: m.mi = wrap(m.mi + dl, 0, 59);
        3: m.h  = wrap(m.h + dl, 0, 23);
        4: m.d  = wrap(m.d + dl, 1, dim(m.mo, m.y));
        5: m.mo = wrap(m.mo + dl, 1, 12);
        default: m.y = wrap(m.y + dl, 0, 9999);
      endcase
      if (m.d > dim(m.mo, m.y)) m.d = dim(m.mo, m.y);
    end
  endtask

  // ---------------- helpers ----------------
  function automatic t_time dut_time();
    t_time a;
    a.s  = int'(bus.second);
    a.mi = int'(bus.minute);
    a.h  = int'(bus.hour);
    a.d  = int'(bus.day);
    a.mo = int'(bus.month);
    a.y  = int'(bus.year);
    return a;
  endfunction

  function automatic bit same(input t_time a, input t_time b);
    return a.s == b.s && a.mi == b.mi && a.h == b.h && a.d == b.d && a.mo == b.mo && a.y == b.y;
  endfunction

  function automatic string fmt(input t_time t);
    return $sformatf("%02d:%02d:%02d %02d/%02d/%04d", t.h, t.mi, t.s, t.d, t.mo, t.y);
  endfunction

  task automatic idle_inputs();
    bus.tick_1hz    = 1'b0;
    bus.select_item = 3'd0;
    bus.inc_pulse   = 1'b0;
    bus.dec_pulse   = 1'b0;
  endtask

  // Drive one cycle of stimulus, predict, and return just after the edge.
  task automatic step(input bit tick, input int sel, input bit inc, input bit dec);
    @(negedge clk);
    bus.tick_1hz    = tick;
    bus.select_item = 3'(sel);
    bus.inc_pulse   = inc;
    bus.dec_pulse   = dec;
    model_update(tick, sel, inc, dec);
    exp_q.push_back(m);
    @(posedge clk);
    #2;
  endtask

  task automatic set_field(input int sel, input int target);
    int n;
    n = 0;
    while (model_get(sel) != target && n < 10000) begin
      step(1'b0, sel, target > model_get(sel), target < model_get(sel));
      n++;
    end
  endtask

  task automatic check_now(input string name, input int h, input int mi, input int s,
                           input int d, input int mo, input int y);
    t_time e;
    t_time a;
    e = '{s: s, mi: mi, h: h, d: d, mo: mo, y: y};
    a = dut_time();
    checks++;
    if (!same(a, e)) begin
      errors++;
      $display("FAIL %s: got %s expected %s", name, fmt(a), fmt(e));
    end
  endtask

  task automatic set_datetime(input int h, input int mi, input int s,
                              input int d, input int mo, input int y);
    set_field(6, y);
    set_field(5, mo);
    set_field(4, d);
    set_field(3, h);
    set_field(2, mi);
    set_field(1, s);
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    t_time e;
    t_time a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_time();
        checks++;
        if (!same(a, e)) begin
          errors++;
          $display("FAIL scoreboard: got %s expected %s", fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    int years[3];
    int sel;
    years = '{2100, 2000, 2024};
    idle_inputs();
    model_reset();
    #12;
    check_now("reset_asserted", 0, 0, 0, 1, 1, 2000);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) step(1'b0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    check_now("no_tick_hold", 0, 0, 0, 1, 1, 2000);
    repeat (3) step(1'b1, 7, 1'b1, 1'b0);
    check_now("run_sel7_ticks", 0, 0, 3, 1, 1, 2000);

    // Full rollover of every field.
    set_datetime(23, 59, 59, 31, 12, 9999);
    check_now("edit_to_max", 23, 59, 59, 31, 12, 9999);
    step(1'b1, 0, 1'b0, 1'b0);
    check_now("year_rollover", 0, 0, 0, 1, 1, 0);

    // Leap-year handling at end of February.
    for (int i = 0; i < 3; i++) begin
      set_datetime(23, 59, 59, 28, 2, years[i]);
      step(1'b1, 0, 1'b0, 1'b0);
      if (years[i] == 2100) check_now("leap_2100", 0, 0, 0, 1, 3, 2100);
      else                  check_now("leap_feb29", 0, 0, 0, 29, 2, years[i]);
    end

    // Day clamp after month and year edits.
    set_datetime(0, 0, 0, 31, 1, 2001);
    step(1'b0, 5, 1'b1, 1'b0);
    check_now("clamp_month", 0, 0, 0, 28, 2, 2001);
    step(1'b0, 6, 1'b0, 1'b1);
    check_now("clamp_year", 0, 0, 0, 28, 2, 2000);

    // Hour wrap on decrement, ticks ignored while editing.
    step(1'b0, 3, 1'b0, 1'b1);
    check_now("hour_dec_wrap", 23, 0, 0, 28, 2, 2000);
    repeat (5) step(1'b1, 3, 1'b0, 1'b0);
    check_now("edit_pauses", 23, 0, 0, 28, 2, 2000);
    step(1'b1, 0, 1'b0, 1'b0);
    check_now("no_catch_up", 23, 0, 1, 28, 2, 2000);

    // Simultaneous inc/dec does nothing; reset overrides an edit immediately.
    step(1'b0, 1, 1'b1, 1'b1);
    check_now("inc_dec_both", 23, 0, 1, 28, 2, 2000);
    bus.select_item = 3'd1;
    bus.inc_pulse   = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    check_now("reset_mid_edit", 0, 0, 0, 1, 1, 2000);
    idle_inputs();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0);
    check_now("post_reset", 0, 0, 0, 1, 1, 2000);

    // Random mix of run and edit traffic.
    repeat (3000) begin
      sel = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 7));
      step(1'($urandom_range(0, 3) == 0), sel,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    // Drive near the year boundary with random traffic too.
    set_datetime(23, 59, 58, 31, 12, 9999);
    repeat (200) begin
      sel = ($urandom_range(0, 2) != 0) ? 0 : int'($urandom_range(1, 6));
      step(1'($urandom_range(0, 1)), sel,
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_calendar_counter.md
CLOCK_CALENDAR_COUNTER -- requirements
Module: clock_calendar_counter

Interface
REQ-001 SHALL have no parameters; all field widths and ranges are fixed by this document.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 tick_1hz  input  1  one-cycle pulse, once per second, synchronous to clk.
REQ-005 select_item  input  3  edit field: 0 none, 1 second, 2 minute, 3 hour, 4 day, 5 month, 6 year, 7 none.
REQ-006 inc_pulse  input  1  one-cycle request: increment selected field.
REQ-007 dec_pulse  input  1  one-cycle request: decrement selected field.
REQ-008 second  output  6  0..59, registered.
REQ-009 minute  output  6  0..59, registered.
REQ-010 hour  output  6  0..23, registered.
REQ-011 day  output  6  1..days_in_month, registered.
REQ-012 month  output  4  1..12, registered.
REQ-013 year  output  14  0..9999, registered.

Function
REQ-014 SHALL operate in RUN mode when select_item is 0 or 7, and in EDIT mode when select_item is 1..6.
REQ-015 RUN mode, tick_1hz=1: second+1; on 59 -> 0, carry to minute; minute 59 -> 0, carry to hour; hour 23 -> 0, carry to day.
REQ-016 Day carry: day == days_in_month -> day 1, month+1; month 12 -> 1, year+1; year 9999 -> 0.
REQ-017 days_in_month SHALL be: Jan/Mar/May/Jul/Aug/Oct/Dec 31; Apr/Jun/Sep/Nov 30; Feb 29 if leap, else 28.
REQ-018 Leap SHALL be: (year mod 4 == 0 AND year mod 100 != 0) OR year mod 400 == 0; year 0 is leap.
REQ-019 Leap and days_in_month SHALL be derived combinationally from the current registered year and month.
REQ-020 All carries SHALL resolve in the same clock edge as the tick; outputs SHALL show the new time one cycle after tick_1hz is sampled.
REQ-021 EDIT mode: tick_1hz SHALL be ignored, with no catch-up afterwards; timekeeping is paused.
REQ-022 EDIT, inc_pulse only: the selected field +1 and wraps to its minimum at its maximum; no carry into other fields.
REQ-023 EDIT, dec_pulse only: the selected field -1 and wraps to its maximum at its minimum; no borrow.
REQ-024 Field ranges for edit wrap: second/minute 0..59, hour 0..23, day 1..days_in_month, month 1..12, year 0..9999.
REQ-025 inc_pulse and dec_pulse both high in the same cycle SHALL change nothing.
REQ-026 In RUN mode, inc_pulse and dec_pulse SHALL be ignored.
REQ-027 After a month or year edit, if day exceeds the new days_in_month, day SHALL be clamped to it.
REQ-028 The clamp SHALL take effect in the same edge as the edit, using the post-edit month and year.
REQ-029 A select_item change SHALL take effect on the next edge; there is no handshake and no internal state beyond the six field registers.
REQ-030 Outputs SHALL never hold an out-of-range value in any cycle.

Reset
REQ-031 rst_n low SHALL immediately set second=0, minute=0, hour=0, day=1, month=1, year=2000, regardless of clk.
REQ-032 Reset asserted mid-edit or mid-carry SHALL override everything; operation resumes on the first edge after release.

Verification
REQ-033 Reset released -> outputs 00:00:00 01/01/2000; no change without tick_1hz.
REQ-034 Edit to 23:59:59 31/12/9999, select 0, one tick -> 00:00:00 01/01/0000 one cycle later.
REQ-035 Leap check, 23:59:59 28/02, one tick each case:
- year 2100 -> 01/03/2100
- year 2000 -> 29/02/2000
- year 2024 -> 29/02/2024
REQ-036 Clamp check, day=31 month=1 year=2001, select=5, inc -> month=2, day=28; then select=6 to 2000, day stays 28.
REQ-037 select=3, hour=0, dec -> hour=23, day unchanged; 5 ticks during the edit -> second unchanged.
REQ-038 inc and dec in the same cycle -> no field change; rst_n pulse during edit -> full reset values immediately.
